// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 keyboard receiver and its
// memory-mapped read port.
//   - register addresses decoded from the bus word address bits [1:0]
//   - bit positions inside the STATUS register
//   - receiver frame state encoding
//   - odd-parity helper used when PS2_PARITY_CHECK_EN is defined
package ps2_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    localparam int unsigned ST_AVAIL   = 0;
    localparam int unsigned ST_OVF     = 1;
    localparam int unsigned ST_FRM_ERR = 2;
    localparam int unsigned ST_PAR_ERR = 3;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    // Odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device->host frame receiver.
//   Synchronises the PS/2 pins, detects falling edges of the PS/2 clock and
//   shifts in 11-bit frames: start(0), D0..D7 LSB first, odd parity, stop(1).
//   A partial frame is abandoned after TIMEOUT_CYC cycles without an edge.
//   Config macro PS2_PARITY_CHECK_EN: when defined, bad parity drops the byte
//   and pulses o_par_err; when undefined the parity bit is ignored.
// Ports:
//   i_clk, i_rst_n      system clock, async active-low reset
//   i_ps2_clk/_data     raw PS/2 pins
//   o_byte              last received byte (valid with o_valid)
//   o_valid             one-cycle pulse: o_byte holds a good byte
//   o_frm_err           one-cycle pulse: stop bit was 0, frame dropped
//   o_par_err           one-cycle pulse: parity bad, frame dropped
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT_CYC = 5000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_byte,
    output logic       o_valid,
    output logic       o_frm_err,
    output logic       o_par_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
    logic                   clk_prev_q;
    logic                   ps2_clk_s, ps2_dat_s, fall;

    rx_state_e state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    byte_q, byte_d;
    logic          valid_q, valid_d;
    logic          frm_q, frm_d;
    logic          perr_q, perr_d;
`ifdef PS2_PARITY_CHECK_EN
    logic          par_q, par_d;
`endif

    assign ps2_clk_s = clk_sync_q[SYNC_STAGES-1];
    assign ps2_dat_s = dat_sync_q[SYNC_STAGES-1];
    assign fall      = clk_prev_q & ~ps2_clk_s;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        byte_d    = byte_q;
        valid_d   = 1'b0;
        frm_d     = 1'b0;
        perr_d    = 1'b0;
        tmo_d     = (state_q == RX_IDLE) ? '0 : tmo_q + TW'(1);
`ifdef PS2_PARITY_CHECK_EN
        par_d     = par_q;
`endif
        if (fall) begin
            tmo_d = '0;
            case (state_q)
                RX_IDLE: begin
                    if (!ps2_dat_s) begin
                        state_d   = RX_DATA;
                        bit_cnt_d = '0;
                    end
                end
                RX_DATA: begin
                    shreg_d   = {ps2_dat_s, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
                end
                RX_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    par_d = ps2_dat_s;
`endif
                    state_d = RX_STOP;
                end
                default: begin
                    state_d = RX_IDLE;
                    if (!ps2_dat_s) begin
                        frm_d = 1'b1;
                    end else begin
`ifdef PS2_PARITY_CHECK_EN
                        if (odd_parity_ok(shreg_q, par_q)) begin
                            byte_d  = shreg_q;
                            valid_d = 1'b1;
                        end else begin
                            perr_d = 1'b1;
                        end
`else
                        byte_d  = shreg_q;
                        valid_d = 1'b1;
`endif
                    end
                end
            endcase
        end else if (state_q != RX_IDLE && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d = RX_IDLE;
            tmo_d   = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // Pins idle high, so synchronisers reset high to avoid a false edge.
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
            state_q    <= RX_IDLE;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            tmo_q      <= '0;
            byte_q     <= '0;
            valid_q    <= 1'b0;
            frm_q      <= 1'b0;
            perr_q     <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            par_q      <= 1'b0;
`endif
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], i_ps2_clk};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], i_ps2_data};
            clk_prev_q <= ps2_clk_s;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            tmo_q      <= tmo_d;
            byte_q     <= byte_d;
            valid_q    <= valid_d;
            frm_q      <= frm_d;
            perr_q     <= perr_d;
`ifdef PS2_PARITY_CHECK_EN
            par_q      <= par_d;
`endif
        end
    end

    assign o_byte    = byte_q;
    assign o_valid   = valid_q;
    assign o_frm_err = frm_q;
    assign o_par_err = perr_q;

endmodule

// File: rtl/ps2_kbd_mem.sv
// ps2_kbd_mem: PS/2 keyboard receiver with a memory-mapped read port.
//   Received scan-code bytes go into a FIFO; a bus master reads them with a
//   req/done handshake (done pulses one cycle after the accepted request).
//   Read map: 0 DATA (pop), 1 STATUS {4'b0,PAR_ERR,FRM_ERR,OVF,AVAIL},
//   2 FIFO count (saturated to 8 bits), 3 zero. Write to 0 flushes FIFO+flags.
//   Config macro PS2_PARITY_CHECK_EN enables parity checking in ps2_rx.
// Ports:
//   i_clk, i_rst_n           system clock, async active-low reset
//   i_ps2_clk, i_ps2_data    PS/2 pins (asynchronous)
//   i_addr, i_req, i_wren    bus request (only i_addr[1:0] decoded)
//   o_out, done              read data and one-cycle completion pulse
module ps2_kbd_mem
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT_CYC = 5000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ps2_clk,
    input  logic        i_ps2_data,
    input  logic [31:0] i_addr,
    input  logic        i_req,
    input  logic        i_wren,
    output logic [7:0]  o_out,
    output logic        done
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0] rx_byte;
    logic       rx_valid, rx_frm_err, rx_par_err;

    ps2_rx #(
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_ps2_clk  (i_ps2_clk),
        .i_ps2_data (i_ps2_data),
        .o_byte     (rx_byte),
        .o_valid    (rx_valid),
        .o_frm_err  (rx_frm_err),
        .o_par_err  (rx_par_err)
    );

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d, frm_q, frm_d, par_q, par_d;
    logic          done_q, done_d;
    logic [7:0]    out_q, out_d;

    logic       accept, rd, flush, full, empty, pop, push, clr_flags;
    logic [1:0] addr;
    logic [7:0] status, count_rpt, rdata;
    logic       unused_addr;

    assign unused_addr = ^i_addr[31:2];
    assign addr        = i_addr[1:0];

    always_comb begin
        // done_q doubles as the busy flag, so a held request re-triggers every 2 cycles.
        accept    = i_req && !done_q;
        rd        = accept && !i_wren;
        flush     = accept && i_wren && (addr == ADDR_DATA);
        full      = (count_q == CW'(FIFO_DEPTH));
        empty     = (count_q == '0);
        pop       = rd && (addr == ADDR_DATA) && !empty;
        push      = rx_valid && (!full || pop);
        clr_flags = rd && (addr == ADDR_STATUS);

        status             = '0;
        status[ST_AVAIL]   = !empty;
        status[ST_OVF]     = ovf_q;
        status[ST_FRM_ERR] = frm_q;
        status[ST_PAR_ERR] = par_q;
        count_rpt = (32'(count_q) > 32'd255) ? 8'hFF : 8'(count_q);

        case (addr)
            ADDR_DATA:   rdata = empty ? 8'h00 : mem_q[rd_ptr_q];
            ADDR_STATUS: rdata = status;
            ADDR_COUNT:  rdata = count_rpt;
            default:     rdata = 8'h00;
        endcase

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);

        // Event set wins over a same-cycle STATUS-read clear so no error is lost.
        ovf_d = (clr_flags ? 1'b0 : ovf_q) | (rx_valid && full && !pop);
        frm_d = (clr_flags ? 1'b0 : frm_q) | rx_frm_err;
        par_d = (clr_flags ? 1'b0 : par_q) | rx_par_err;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            frm_d    = 1'b0;
            par_d    = 1'b0;
        end

        done_d = accept;
        out_d  = accept ? (rd ? rdata : 8'h00) : out_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            frm_q    <= 1'b0;
            par_q    <= 1'b0;
            done_q   <= 1'b0;
            out_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            frm_q    <= frm_d;
            par_q    <= par_d;
            done_q   <= done_d;
            out_q    <= out_d;
        end
    end

    // Storage needs no reset: entries are only read when count marks them valid.
    always_ff @(posedge i_clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= rx_byte;
    end

    assign o_out = out_q;
    assign done  = done_q;

endmodule

// File: tb/tb_ps2_kbd_mem.sv
module tb_ps2_kbd_mem;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [31:0] addr = '0;
    logic        req = 1'b0;
    logic        wren = 1'b0;
    logic [7:0]  o_out;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ps2_kbd_mem #(
        .FIFO_DEPTH  (16),
        .SYNC_STAGES (2),
        .TIMEOUT_CYC (5000)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_ps2_clk  (ps2_clk),
        .i_ps2_data (ps2_data),
        .i_addr     (addr),
        .i_req      (req),
        .i_wren     (wren),
        .o_out      (o_out),
        .done       (done)
    );

    // Drive nbits of a frame (start, data, parity, stop) with 40-unit half-periods.
    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                              input int nbits);
        logic [10:0] f;
        logic        par;
        par = ~^d;
        if (bad_par) par = ~par;
        f = {~bad_stop, par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            #40 ps2_clk = 1'b0;
            #40 ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        #200;
    endtask

    // One bus access; hs=1 when done was low, pulsed one cycle after req, then low.
    task automatic access(input logic [1:0] a, input bit wr, output logic [7:0] d,
                          output bit hs);
        logic pre, d1, d2;
        @(negedge clk);
        pre  = done;
        addr = {30'd0, a};
        wren = wr;
        req  = 1'b1;
        @(negedge clk);
        req  = 1'b0;
        d1   = done;
        d    = o_out;
        @(negedge clk);
        d2   = done;
        hs   = (pre === 1'b0) && (d1 === 1'b1) && (d2 === 1'b0);
    endtask

    task automatic test_reset();
        logic [7:0] d;
        bit hs;
        send_frame(8'h1C, 0, 0, 11);
        send_frame(8'h33, 0, 0, 11);
        access(2'd0, 0, d, hs);
        n_tests++;
        if (d !== 8'h1C) begin n_fail++; $display("FAIL pre_reset_data: got %h want 1c", d); end
        send_frame(8'h77, 0, 0, 5);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (o_out !== 8'h00) begin n_fail++; $display("FAIL reset_o_out: got %h want 00", o_out); end
        n_tests++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        #40;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        access(2'd1, 0, d, hs);
        n_tests++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL reset_status: got %h want 00", d); end
        n_tests++;
        if (hs !== 1'b1) begin n_fail++; $display("FAIL reset_status_done: got %b want 1", hs); end
        access(2'd2, 0, d, hs);
        n_tests++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL reset_count: got %h want 00", d); end
    endtask

    task automatic test_two_frames();
        logic [7:0] d;
        bit hs;
        send_frame(8'h1C, 0, 0, 11);
        send_frame(8'h5A, 0, 0, 11);
        access(2'd0, 0, d, hs);
        n_tests++;
        if (d !== 8'h1C) begin n_fail++; $display("FAIL read1_data: got %h want 1c", d); end
        n_tests++;
        if (hs !== 1'b1) begin n_fail++; $display("FAIL read1_done: got %b want 1", hs); end
        access(2'd0, 0, d, hs);
        n_tests++;
        if (d !== 8'h5A) begin n_fail++; $display("FAIL read2_data: got %h want 5a", d); end
        n_tests++;
        if (hs !== 1'b1) begin n_fail++; $display("FAIL read2_done: got %b want 1", hs); end
        access(2'd0, 0, d, hs);
        n_tests++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL read_empty: got %h want 00", d); end
        access(2'd3, 0, d, hs);
        n_tests++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL read_addr3: got %h want 00", d); end
    endtask

    task automatic test_parity();
        logic [7:0] d;
        bit hs;
        logic [7:0] exp_st, exp_d;
`ifdef PS2_PARITY_CHECK_EN
        exp_st = 8'h08;
        exp_d  = 8'h00;
`else
        exp_st = 8'h01;
        exp_d  = 8'h1C;
`endif
        send_frame(8'h1C, 1, 0, 11);
        access(2'd1, 0, d, hs);
        n_tests++;
        if (d !== exp_st) begin n_fail++; $display("FAIL parity_status: got %h want %h", d, exp_st); end
        access(2'd0, 0, d, hs);
        n_tests++;
        if (d !== exp_d) begin n_fail++; $display("FAIL parity_data: got %h want %h", d, exp_d); end
        access(2'd1, 0, d, hs);
        n_tests++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL parity_status_clr: got %h want 00", d); end
    endtask

    task automatic test_frame_err();
        logic [7:0] d;
        bit hs;
        send_frame(8'h12, 0, 1, 11);
        access(2'd1, 0, d, hs);
        n_tests++;
        if (d !== 8'h04) begin n_fail++; $display("FAIL frm_status: got %h want 04", d); end
        access(2'd1, 0, d, hs);
        n_tests++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL frm_status_clr: got %h want 00", d); end
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        bit hs;
        for (int i = 0; i < 17; i++) send_frame(8'h20 + 8'(i), 0, 0, 11);
        access(2'd2, 0, d, hs);
        n_tests++;
        if (d !== 8'h10) begin n_fail++; $display("FAIL ovf_count: got %h want 10", d); end
        access(2'd1, 0, d, hs);
        n_tests++;
        if (d !== 8'h03) begin n_fail++; $display("FAIL ovf_status: got %h want 03", d); end
        access(2'd1, 0, d, hs);
        n_tests++;
        if (d !== 8'h01) begin n_fail++; $display("FAIL ovf_status_clr: got %h want 01", d); end
        for (int i = 0; i < 16; i++) begin
            access(2'd0, 0, d, hs);
            n_tests++;
            if (d !== 8'h20 + 8'(i)) begin
                n_fail++;
                $display("FAIL ovf_read%0d: got %h want %h", i, d, 8'h20 + 8'(i));
            end
        end
        access(2'd2, 0, d, hs);
        n_tests++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL ovf_drained: got %h want 00", d); end
    endtask

    task automatic test_timeout();
        logic [7:0] d;
        bit hs;
        send_frame(8'hAB, 0, 0, 5);
        repeat (5100) @(posedge clk);
        send_frame(8'hF0, 0, 0, 11);
        access(2'd0, 0, d, hs);
        n_tests++;
        if (d !== 8'hF0) begin n_fail++; $display("FAIL timeout_data: got %h want f0", d); end
        access(2'd2, 0, d, hs);
        n_tests++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL timeout_count: got %h want 00", d); end
    endtask

    task automatic test_flush();
        logic [7:0] d;
        bit hs;
        send_frame(8'h01, 0, 0, 11);
        send_frame(8'h02, 0, 0, 11);
        send_frame(8'h03, 0, 0, 11);
        send_frame(8'h44, 0, 1, 11);
        access(2'd2, 0, d, hs);
        n_tests++;
        if (d !== 8'h03) begin n_fail++; $display("FAIL flush_pre_count: got %h want 03", d); end
        access(2'd0, 1, d, hs);
        n_tests++;
        if (hs !== 1'b1) begin n_fail++; $display("FAIL flush_done: got %b want 1", hs); end
        access(2'd2, 0, d, hs);
        n_tests++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL flush_count: got %h want 00", d); end
        access(2'd1, 0, d, hs);
        n_tests++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL flush_status: got %h want 00", d); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_o [5];
        logic       exp_dn [5];
        exp_o  = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33};
        exp_dn = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        send_frame(8'h11, 0, 0, 11);
        send_frame(8'h22, 0, 0, 11);
        send_frame(8'h33, 0, 0, 11);
        @(negedge clk);
        addr = '0;
        wren = 1'b0;
        req  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 4) req = 1'b0;
            n_tests++;
            if (done !== exp_dn[i] || o_out !== exp_o[i]) begin
                n_fail++;
                $display("FAIL b2b_cycle%0d: got done=%b out=%h want done=%b out=%h",
                         i, done, o_out, exp_dn[i], exp_o[i]);
            end
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_done: got %b want 0", done); end
    endtask

    initial begin
        #50;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        test_two_frames();
        test_parity();
        test_frame_err();
        test_overflow();
        test_timeout();
        test_flush();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
